// File: rtl/dram_bank.sv
// dram_bank: parametrised single-port data bank with a valid/ready request channel and a response channel.
// Optional build macro DRAM_MISALIGN_ERR_EN: reject misaligned accesses instead of aligning them down.
module dram_bank #(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       DEPTH     = 4096,
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       RD_LAT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int unsigned      NB         = DATA_W / 8;
    localparam int unsigned      LANE_W     = $clog2(NB);
    localparam int unsigned      IDX_W      = $clog2(DEPTH);
    localparam int unsigned      CNT_W      = 2;
    localparam logic [ADDR_W:0]  BANK_BYTES = (ADDR_W+1)'(DEPTH * NB);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [ADDR_W-1:0]  off_c;
    logic [LANE_W-1:0]  lane_raw_c;
    logic [LANE_W-1:0]  size_mask_c;
    logic [LANE_W-1:0]  lane_c;
    logic [IDX_W-1:0]   idx_c;
    logic [7:0]         size_be_c;
    logic [NB-1:0]      be_c;
    logic [DATA_W-1:0]  wdata_c;
    logic               in_range_c;
    logic               size_err_c;
    logic               err_c;
    logic               accept_c;
    logic               we_c;

    // Array is zeroed once at time 0; reset deliberately leaves contents alone.
    logic [DATA_W-1:0]  mem_q [DEPTH] = '{default: '0};

    // Address decode, byte-enable and write-data alignment for the presented request.
    always_comb begin
        off_c       = req_addr_i - BASE_ADDR;
        in_range_c  = {1'b0, off_c} < BANK_BYTES;
        size_err_c  = 32'(req_size_i) > LANE_W;
        lane_raw_c  = off_c[LANE_W-1:0];
        size_mask_c = LANE_W'((4'd1 << req_size_i) - 4'd1);
        lane_c      = lane_raw_c & ~size_mask_c;
        idx_c       = off_c[LANE_W +: IDX_W];
        case (req_size_i)
            2'd0:    size_be_c = 8'h01;
            2'd1:    size_be_c = 8'h03;
            2'd2:    size_be_c = 8'h0F;
            default: size_be_c = 8'hFF;
        endcase
        be_c    = NB'(size_be_c) << lane_c;
        wdata_c = req_wdata_i << {lane_c, 3'b000};
`ifdef DRAM_MISALIGN_ERR_EN
        err_c   = !in_range_c || size_err_c || (|(lane_raw_c & size_mask_c));
`else
        err_c   = !in_range_c || size_err_c;
`endif
        accept_c = req_valid_i && req_ready_o && !rst_i;
        we_c     = accept_c && req_we_i && !err_c;
    end

    // Writes commit on the accept edge, byte lanes outside the access untouched.
    always_ff @(posedge clk_i) begin
        if (we_c) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (be_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
                end
            end
        end
    end

    // Request/response sequencing; read data is captured at accept and held until the response handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        req_ready_o <= 1'b0;
                        rsp_err_o   <= err_c;
                        rsp_rdata_o <= (err_c || req_we_i) ? '0 : mem_q[idx_c];
                        if (RD_LAT > 1) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(RD_LAT - 2);
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_o <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        req_ready_o <= 1'b1;
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                    rsp_rdata_o <= '0;
                    rsp_err_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_bank.sv
// tb_dram_bank: directed self-checking bench for dram_bank (64-bit, 16 words, relocated base, 3-cycle latency).
module tb_dram_bank;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned RD_LAT = 3;
    localparam logic [63:0] B      = 64'h0000_0000_8000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dram_bank #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(B),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_we_i   (req_we),
        .req_size_i (req_size),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns just after the accept edge.
    task automatic issue(input logic [63:0] a, input logic we, input logic [1:0] sz, input logic [63:0] wd);
        req_addr  = a;
        req_we    = we;
        req_size  = sz;
        req_wdata = wd;
        req_valid = 1'b1;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(RD_LAT));
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    task automatic access(input string tag, input logic [63:0] a, input logic we, input logic [1:0] sz,
                          input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err);
        issue(a, we, sz, wd);
        wait_rsp(tag);
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
        finish_rsp(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_size  = 2'd0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);

        // Dword write then read back.
        access("wr10", B + 64'h10, 1'b1, 2'd3, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
        access("rd10", B + 64'h10, 1'b0, 2'd3, 64'd0, 64'h1122_3344_5566_7788, 1'b0);

        // Sized writes merge into one word; upper write-data bits must be ignored.
        access("wr20", B + 64'h20, 1'b1, 2'd3, 64'd0, 64'd0, 1'b0);
        access("wb23", B + 64'h23, 1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 64'd0, 1'b0);
        access("wh26", B + 64'h26, 1'b1, 2'd1, 64'h1234_5678_9ABC_BEEF, 64'd0, 1'b0);
        access("rd20", B + 64'h20, 1'b0, 2'd3, 64'd0, 64'hBEEF_0000_AB00_0000, 1'b0);

        // Range boundaries around the relocated window.
        access("wr00", B + 64'h00, 1'b1, 2'd3, 64'h0102_0304_0506_0708, 64'd0, 1'b0);
        access("wr78", B + 64'h78, 1'b1, 2'd3, 64'h5A5A_A5A5_5A5A_A5A5, 64'd0, 1'b0);
        access("rd_below", 64'h0000_0000_7FFF_FFF8, 1'b0, 2'd3, 64'd0, 64'd0, 1'b1);
        access("rd_above", B + 64'h80, 1'b0, 2'd3, 64'd0, 64'd0, 1'b1);
        access("wr_above", B + 64'h80, 1'b1, 2'd3, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1'b1);
        access("rd78", B + 64'h78, 1'b0, 2'd3, 64'd0, 64'h5A5A_A5A5_5A5A_A5A5, 1'b0);
        access("rd00", B + 64'h00, 1'b0, 2'd3, 64'd0, 64'h0102_0304_0506_0708, 1'b0);

        // Backpressured response stays stable; a request pulse meanwhile is ignored.
        issue(B + 64'h10, 1'b0, 2'd3, 64'd0);
        wait_rsp("hold");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_addr  = B + 64'h50;
                req_we    = 1'b1;
                req_size  = 2'd3;
                req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
                req_valid = 1'b1;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rdata", rsp_rdata, 64'h1122_3344_5566_7788);
            chk("hold_err", 64'(rsp_err), 64'd0);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        finish_rsp("hold");
        access("rd50", B + 64'h50, 1'b0, 2'd3, 64'd0, 64'd0, 1'b0);

        // Misaligned half write.
        access("wr30", B + 64'h30, 1'b1, 2'd3, 64'h8877_6655_4433_2211, 64'd0, 1'b0);
`ifdef DRAM_MISALIGN_ERR_EN
        access("wh31", B + 64'h31, 1'b1, 2'd1, 64'h1234, 64'd0, 1'b1);
        access("rd30", B + 64'h30, 1'b0, 2'd3, 64'd0, 64'h8877_6655_4433_2211, 1'b0);
`else
        access("wh31", B + 64'h31, 1'b1, 2'd1, 64'h1234, 64'd0, 1'b0);
        access("rd30", B + 64'h30, 1'b0, 2'd3, 64'd0, 64'h8877_6655_4433_1234, 1'b0);
`endif

        // Reset while waiting: response dropped, write kept.
        issue(B + 64'h40, 1'b1, 2'd0, 64'hFF);
        chk("midrst_wait_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        repeat (RD_LAT) @(posedge clk);
        #1;
        chk("midrst_no_late_rsp", 64'(rsp_valid), 64'd0);
        access("rd40", B + 64'h40, 1'b0, 2'd3, 64'd0, 64'h0000_0000_0000_00FF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
